// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// operation encodings, the FSM state type and the default operand width.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the unsigned datapath: shift-add multiply step or
// restoring shift-subtract divide step on a 2*WIDTH accumulator.
module muldiv_core import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;

  always_comb begin
    // MUL: acc = {partial, multiplier}; add on LSB, then shift right.
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc[0]}} & {1'b0, opnd});
    // DIV: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    rem_ge    = rem_shift >= {1'b0, opnd};
    // Only taken when rem_ge, where the true difference is below 2^WIDTH.
    rem_diff  = rem_shift[WIDTH-1:0] - opnd;
    if (div_mode) begin
      if (rem_ge) acc_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
      else        acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO updates: runs one
// bit per cycle, applies sign correction, then strobes multWe for one cycle.
module muldiv_seq import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   srcA,
  input  logic [WIDTH-1:0]   srcB,
  input  logic               hilo_rd,
  input  logic               hilo_wr,
  input  logic               flush,
  output logic               busy,
  output logic               stall,
  output logic               multWe,
  output logic [2*WIDTH-1:0] busmult
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e          state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg, acc_step, result, busmult_reg;
  logic [WIDTH-1:0]   opnd_reg, mag_a, mag_b, quot, rem;
  logic               div_reg, dz_reg, negq_reg, negr_reg;
  logic               sgn_a, sgn_b, last_step;

  assign sgn_a     = md_is_signed(op) & srcA[WIDTH-1];
  assign sgn_b     = md_is_signed(op) & srcB[WIDTH-1];
  assign mag_a     = sgn_a ? -srcA : srcA;
  assign mag_b     = sgn_b ? -srcB : srcB;
  // Divide-by-zero leaves RUN after its first cycle.
  assign last_step = (count_reg == CW'(WIDTH - 1)) | dz_reg;
  assign busmult   = busmult_reg;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .div_mode (div_reg),
    .acc      (acc_reg),
    .opnd     (opnd_reg),
    .acc_next (acc_step)
  );

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    multWe     = 1'b0;
    case (state_reg)
      IDLE: if (start && !flush) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (flush)          state_next = IDLE;
        else if (last_step) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = flush ? IDLE : DONE;
      end
      DONE: begin
        multWe     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    stall = (busy | multWe) & (hilo_rd | hilo_wr | start);
  end

  always_comb begin
    quot = negq_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem  = negr_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    if (dz_reg)       result = acc_reg;
    else if (div_reg) result = {rem, quot};
    else              result = negq_reg ? -acc_reg : acc_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      div_reg     <= 1'b0;
      dz_reg      <= 1'b0;
      negq_reg    <= 1'b0;
      negr_reg    <= 1'b0;
      busmult_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          count_reg <= '0;
          if (state_next == RUN) begin
            div_reg  <= md_is_div(op);
            dz_reg   <= md_is_div(op) && (srcB == '0);
            negq_reg <= sgn_a ^ sgn_b;
            negr_reg <= sgn_a & md_is_div(op);
            if (md_is_div(op) && (srcB == '0)) begin
              acc_reg  <= {srcA, {WIDTH{1'b1}}};
              opnd_reg <= mag_b;
            end else if (md_is_div(op)) begin
              acc_reg  <= {{WIDTH{1'b0}}, mag_a};
              opnd_reg <= mag_b;
            end else begin
              acc_reg  <= {{WIDTH{1'b0}}, mag_b};
              opnd_reg <= mag_a;
            end
          end
        end
        RUN: begin
          count_reg <= count_reg + CW'(1);
          if (!dz_reg) acc_reg <= acc_step;
        end
        FIX: if (!flush) busmult_reg <= result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random
// operations compared against a plain-arithmetic HI/LO reference model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, hilo_rd, hilo_wr, flush;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, stall, multWe;
  logic [63:0] busmult;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .srcA    (srcA),
    .srcB    (srcB),
    .hilo_rd (hilo_rd),
    .hilo_wr (hilo_wr),
    .flush   (flush),
    .busy    (busy),
    .stall   (stall),
    .multWe  (multWe),
    .busmult (busmult)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {HI,LO} as the architecture defines it, computed with 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          uq = sq;
          ur = sr;
          p  = {ur[31:0], uq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          p  = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Called just after a posedge with the FSM idle; start is sampled at the next edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit rd);
    logic [63:0] exp;
    int          cyc, lat;
    bit          seen, stall_ok, busy1;
    exp  = ref_model(o, a, b);
    lat  = (o[1] && b == 32'd0) ? 3 : 34;
    op = o; srcA = a; srcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; srcA = $urandom; srcB = $urandom;
    cyc = 1; seen = 0; stall_ok = 1; busy1 = 0;
    while (!seen && cyc <= 80) begin
      @(negedge clk);
      if (cyc == 1) busy1 = busy;
      if (hilo_rd && stall !== 1'b1) stall_ok = 0;
      if (multWe === 1'b1) seen = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
        if (rd && cyc >= 5) hilo_rd = 1'b1;
      end
    end
    check("timeout", 64'(seen), 64'd1);
    check("latency", 64'(cyc), 64'(lat));
    check("result", busmult, exp);
    check("busy_run", 64'(busy1), 64'd1);
    check("stall_hold", 64'(stall_ok), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("we_pulse", 64'(multWe), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("stall_idle", 64'(stall), 64'd0);
    check("result_held", busmult, exp);
    hilo_rd = 1'b0;
    $display("op=%0d a=%h b=%h busmult=%h expected=%h latency=%0d", o, a, b, busmult, exp, cyc);
    @(posedge clk); #1;
  endtask

  task automatic flush_test();
    logic [63:0] prev;
    bit          we_seen, busy11;
    prev = busmult;
    op = MD_DIV; srcA = $urandom; srcB = $urandom | 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    we_seen = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (multWe) we_seen = 1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    busy11 = busy;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (multWe) we_seen = 1;
    end
    check("flush_busy", 64'(busy11), 64'd0);
    check("flush_no_we", 64'(we_seen), 64'd0);
    check("flush_keep", busmult, prev);
    $display("flush DIV at cycle 10, busmult=%h", busmult);
    @(posedge clk); #1;
  endtask

  task automatic reset_test();
    hilo_rd = 1'b1;
    op = MD_MULTU; srcA = $urandom | 32'd1; srcB = $urandom | 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_pre_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_we", 64'(multWe), 64'd0);
    check("rst_busmult", busmult, 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    $display("async reset mid-RUN, busmult=%h", busmult);
    @(posedge clk); #1;
    rst = 1'b0;
    hilo_rd = 1'b0;
    @(posedge clk); #1;
  endtask

  // A second start held through the first op must stall, then run once idle.
  task automatic two_start(input logic [1:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                           input logic [1:0] o2, input logic [31:0] a2, input logic [31:0] b2);
    logic [63:0] e1, e2;
    bit          seen, stall_ok, extra;
    int          n;
    e1 = ref_model(o1, a1, b1);
    e2 = ref_model(o2, a2, b2);
    op = o1; srcA = a1; srcB = b1; start = 1'b1;
    @(posedge clk); #1;
    op = o2; srcA = a2; srcB = b2;
    seen = 0; stall_ok = 1; n = 1;
    while (!seen && n <= 80) begin
      @(negedge clk);
      if (stall !== 1'b1) stall_ok = 0;
      if (multWe === 1'b1) seen = 1;
      else begin @(posedge clk); #1; n++; end
    end
    check("ts1_seen", 64'(seen), 64'd1);
    check("ts1_result", busmult, e1);
    check("ts1_stall", 64'(stall_ok), 64'd1);
    $display("two-start first op=%0d busmult=%h expected=%h", o1, busmult, e1);
    @(posedge clk); #1;
    @(negedge clk);
    check("ts_idle_stall", 64'(stall), 64'd0);
    check("ts_idle_we", 64'(multWe), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; srcA = $urandom; srcB = $urandom;
    seen = 0; n = 1;
    while (!seen && n <= 80) begin
      @(negedge clk);
      if (multWe === 1'b1) seen = 1;
      else begin @(posedge clk); #1; n++; end
    end
    check("ts2_seen", 64'(seen), 64'd1);
    check("ts2_latency", 64'(n), 64'd34);
    check("ts2_result", busmult, e2);
    $display("two-start second op=%0d busmult=%h expected=%h", o2, busmult, e2);
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (multWe) extra = 1;
    end
    check("ts_no_third", 64'(extra), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
    hilo_rd = 1'b0; hilo_wr = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_we", 64'(multWe), 64'd0);
    check("reset_busmult", busmult, 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7,        1'b0);
    run_op(MD_DIVU,  32'd100,       32'd7,        1'b0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,        1'b0);
    run_op(MD_DIV,   32'h1234_5678, 32'd0,        1'b0);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(MD_DIVU,  32'h8000_0000, 32'd0,        1'b0);

    flush_test();
    reset_test();
    two_start(MD_MULT, 32'hFFFF_FF00, 32'd3, MD_DIV, 32'd1000, 32'hFFFF_FFF6);

    for (int i = 0; i < 24; i++) begin
      run_op(2'($urandom_range(0, 3)), pick_val(), pick_val(), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
